// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared encodings for the datapath controller
// Holds the opcode/op constants, the writeback-source encodings, the FSM state
// encoding and the decoded instruction classes.
package datapath_ctrl_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

  typedef enum logic [2:0] {
    ST_WAIT, ST_DECODE, ST_GET_A, ST_GET_B, ST_ALU, ST_WR_REG, ST_WR_IMM
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_MOV_IMM, CLS_MOV_REG, CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN
  } instr_cls_t;

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// rtl/datapath_ctrl_instr_dec.sv - combinational instruction field extract and class decode
// Ports:
//   ir      in  16  instruction register contents
//   opcode  out 3   IR[15:13]
//   op      out 2   IR[12:11]
//   rn/rd/rm out 3  register indices IR[10:8] / IR[7:5] / IR[2:0]
//   sh      out 2   shifter control IR[4:3]
//   sximm8  out 16  sign-extended IR[7:0]
//   cls     out     decoded instruction class
module instr_dec
  import datapath_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output instr_cls_t  cls
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
      else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = CLS_ADD;
        OP_CMP:  cls = CLS_CMP;
        OP_AND:  cls = CLS_AND;
        default: cls = CLS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - instruction register and Moore control FSM for the datapath
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in, load           instruction word and IR capture strobe (honoured in WAIT only)
//   s                  start execution of the instruction held in IR
//   w                  idle/waiting
//   readnum, writenum  register-file read/write indices
//   write              register-file write enable
//   loada/loadb/loadc/loads  operand, result and status latch enables
//   asel, bsel, vsel   operand and writeback source selects
//   alu_op, shift      ALU operation and B shifter control
//   sximm8             sign-extended IR[7:0]
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  alu_op,
  output logic [1:0]  shift,
  output logic [15:0] sximm8
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  instr_cls_t  cls;

  instr_dec u_dec (
    .ir     (ir_q),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    alu_op   = 2'b00;
    shift    = 2'b00;

    case (state_q)
      ST_WAIT: begin
        w = 1'b1;
        // IR is only writable while idle so an in-flight instruction is stable.
        if (load) ir_d = in;
        if (s)    state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (cls)
          CLS_MOV_IMM:                 state_d = ST_WR_IMM;
          CLS_ADD, CLS_CMP, CLS_AND:   state_d = ST_GET_A;
          CLS_MOV_REG, CLS_MVN:        state_d = ST_GET_B;
          default:                     state_d = ST_WAIT;
        endcase
      end
      ST_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = ST_GET_B;
      end
      ST_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = sh;
        state_d = ST_ALU;
      end
      ST_ALU: begin
        shift = sh;
        // Single-operand forms run as 0 <op> B, so A is forced to zero.
        asel   = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
        alu_op = (opcode == OPC_ALU) ? op : 2'b00;
        if (cls == CLS_CMP) begin
          loads   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = ST_WR_REG;
        end
      end
      ST_WR_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WR_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
        state_d  = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - self-checking bench for datapath_ctrl
module tb_datapath_ctrl;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] alu_op;
    logic [1:0] shift;
  } out_t;

  logic        clk = 1'b0;
  logic        reset, load, s;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, alu_op, shift;
  logic [15:0] sximm8;

  int total = 0;
  int bad   = 0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  datapath_ctrl dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .alu_op(alu_op),
    .shift(shift), .sximm8(sximm8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t observed();
    out_t o;
    o = '{w, readnum, writenum, write, loada, loadb, loadc, loads,
          asel, bsel, vsel, alu_op, shift};
    return o;
  endfunction

  function automatic out_t idle();
    out_t r;
    r = '0;
    r.w = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] sx(input logic [15:0] ir);
    return {{8{ir[7]}}, ir[7:0]};
  endfunction

  task automatic chk_out(input string tag, input out_t e);
    out_t o;
    o = observed();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected per-cycle outputs from the cycle after s is sampled up to (not
  // including) the return to idle, written as the instruction's micro-steps.
  task automatic build_trace(input logic [15:0] ir);
    out_t c;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    string cname;
    opc = ir[15:13]; op = ir[12:11];
    rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    case ({opc, op})
      5'b11010: cname = "movi";
      5'b11000: cname = "movr";
      5'b10100: cname = "add";
      5'b10101: cname = "cmp";
      5'b10110: cname = "and";
      5'b10111: cname = "mvn";
      default:  cname = "bad";
    endcase
    exp_q.delete();
    c = '0;
    exp_q.push_back(c);                       // decode: nothing asserted
    if (cname == "movi") begin
      c = '0; c.writenum = rn; c.vsel = 2'b01; c.write = 1'b1;
      exp_q.push_back(c);
    end else if (cname != "bad") begin
      if (cname == "add" || cname == "cmp" || cname == "and") begin
        c = '0; c.readnum = rn; c.loada = 1'b1;
        exp_q.push_back(c);
      end
      c = '0; c.readnum = rm; c.loadb = 1'b1; c.shift = sh;
      exp_q.push_back(c);
      c = '0; c.shift = sh;
      c.asel   = (cname == "movr" || cname == "mvn");
      c.alu_op = (opc == 3'b101) ? op : 2'b00;
      if (cname == "cmp") c.loads = 1'b1;
      else                c.loadc = 1'b1;
      exp_q.push_back(c);
      if (cname != "cmp") begin
        c = '0; c.writenum = rd; c.vsel = 2'b00; c.write = 1'b1;
        exp_q.push_back(c);
      end
    end
  endtask

  // Loads ir, starts it and follows it cycle by cycle. abort_at >= 0 applies
  // reset (together with load and s) at that micro-step. hold_s keeps s high
  // to exercise back-to-back issue of the same instruction.
  task automatic run_instr(input logic [15:0] ir, input int abort_at, input bit hold_s);
    in = ir; load = 1'b1; s = 1'b0;
    tick();
    load = 1'b0;
    chk_out("wait_pre", idle());
    chk16("ir_load", sximm8, sx(ir));
    s = 1'b1;
    tick();
    build_trace(ir);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b1; load = 1'b1; s = 1'b1; in = 16'hFFFF;
        tick();
        reset = 1'b0; load = 1'b0; s = 1'b0;
        chk_out("abort_wait", idle());
        chk16("abort_sx", sximm8, 16'h0000);
        tick();
        chk_out("abort_quiet", idle());
        return;
      end
      chk_out($sformatf("step%0d", i), exp_q[i]);
      chk16("sx_hold", sximm8, sx(ir));
      // load/in/s are don't-cares outside idle and must not disturb IR
      load = 1'($urandom); in = 16'($urandom);
      s = hold_s ? 1'b1 : 1'($urandom);
      tick();
    end
    load = 1'b0;
    s = hold_s ? 1'b1 : 1'b0;
    chk_out("done_wait", idle());
    chk16("sx_done", sximm8, sx(ir));
    if (hold_s) begin
      tick();
      s = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        chk_out($sformatf("b2b%0d", i), exp_q[i]);
        tick();
      end
      chk_out("b2b_wait", idle());
    end
  endtask

  localparam logic [4:0] LEGAL [6] = '{5'b11010, 5'b11000, 5'b10100,
                                       5'b10101, 5'b10110, 5'b10111};

  initial begin
    logic [15:0] ir;
    int ab;
    reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    chk_out("reset_out", idle());
    chk16("reset_sx", sximm8, 16'h0000);

    run_instr(16'hD3FB, -1, 1'b0);   // MOV R3,#-5
    run_instr(16'hA148, -1, 1'b0);   // ADD R2,R1,R0 LSL#1
    run_instr(16'hAD06, -1, 1'b0);   // CMP R5,R6
    run_instr(16'h0000, -1, 1'b0);   // illegal
    run_instr(16'hA148, 2, 1'b0);    // reset during GET_B
    run_instr(16'hA148, -1, 1'b1);   // back-to-back issue
    run_instr(16'hDBE0, -1, 1'b1);

    for (int n = 0; n < 200; n++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ir[15:11] = LEGAL[$urandom_range(0, 5)];
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(ir, ab, 1'($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
